// File: rtl/ahb_matrix_decoder_param.sv
// Per-input-port AHB matrix decoder: region-table routing, response mux and default slave.
// Optional DECODE_ERR_CAPTURE_EN adds first-decode-error address capture (err_clr/err_flag/err_addr).
module ahb_matrix_decoder_param #(
    parameter int NUM_PORTS   = 3,
    parameter int NUM_REGIONS = 5,
    parameter int ADDR_LSB    = 10,
    parameter int DATA_W      = 32,
    parameter int USER_W      = 32,
    parameter int REMAP_W     = 1,
    parameter logic [NUM_REGIONS*(32-ADDR_LSB)-1:0] REGION_BASE =
        {22'h200000, 22'h140000, 22'h0C0000, 22'h000000, 22'h000000},
    parameter logic [NUM_REGIONS*(32-ADDR_LSB)-1:0] REGION_LIMIT =
        {22'h27FFFF, 22'h1FFFFF, 22'h13FFFF, 22'h0BFFFF, 22'h00007F},
    parameter logic [NUM_REGIONS*3-1:0] REGION_PORT =
        {3'd2, 3'd1, 3'd1, 3'd0, 3'd1},
    parameter logic [NUM_REGIONS*REMAP_W-1:0] REGION_REMAP =
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b1}
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic [REMAP_W-1:0]          remapping_dec,
    input  logic                        HREADYS,
    input  logic                        sel_dec,
    input  logic [31-ADDR_LSB:0]        decode_addr_dec,
    input  logic [1:0]                  trans_dec,
    input  logic [NUM_PORTS-1:0]        active_dec_in,
    input  logic [NUM_PORTS-1:0]        readyout_dec,
    input  logic [2*NUM_PORTS-1:0]      resp_dec,
    input  logic [DATA_W*NUM_PORTS-1:0] rdata_dec,
    input  logic [USER_W*NUM_PORTS-1:0] ruser_dec,
    output logic [NUM_PORTS-1:0]        sel_dec_out,
    output logic                        active_dec,
    output logic                        HREADYOUTS,
    output logic [1:0]                  HRESPS,
    output logic [DATA_W-1:0]           HRDATAS,
    output logic [USER_W-1:0]           HRUSERS
`ifdef DECODE_ERR_CAPTURE_EN
    ,
    input  logic                        err_clr,
    output logic                        err_flag,
    output logic [31-ADDR_LSB:0]        err_addr
`endif
);

    localparam int AW = 32 - ADDR_LSB;
    localparam int PW = $clog2(NUM_PORTS + 1);
    localparam logic [PW-1:0] DFT = PW'(NUM_PORTS);
    localparam logic [1:0] OKAY  = 2'b00;
    localparam logic [1:0] ERROR = 2'b01;

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

    ds_state_t       r_ds_state;
    ds_state_t       w_ds_next;
    logic [PW-1:0]   r_data_port;
    logic [PW-1:0]   w_hit_port;
    logic [PW-1:0]   w_addr_port;
    logic            w_sel_dft;
    logic            w_ds_start;
    logic            w_ds_ready;
    logic [1:0]      w_ds_resp;

    function automatic logic region_en(input int i);
        logic [REMAP_W-1:0] m;
        m = REGION_REMAP[i*REMAP_W +: REMAP_W];
        return (m == '0) || ((remapping_dec & m) != '0);
    endfunction

    function automatic logic [PW-1:0] region_port(input int i);
        logic [2:0] p;
        p = REGION_PORT[i*3 +: 3];
        if (int'(p) >= NUM_PORTS) return DFT;
        return PW'(p);
    endfunction

    // Walk from the highest index down so the lowest matching region wins
    always_comb begin
        w_hit_port = DFT;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (region_en(i) &&
                decode_addr_dec >= REGION_BASE[i*AW +: AW] &&
                decode_addr_dec <= REGION_LIMIT[i*AW +: AW])
                w_hit_port = region_port(i);
        end
        w_addr_port = (trans_dec == 2'b00) ? r_data_port : w_hit_port;
    end

    always_comb begin
        sel_dec_out = '0;
        active_dec  = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_addr_port == PW'(i)) begin
                sel_dec_out[i] = sel_dec;
                active_dec     = active_dec_in[i];
            end
        end
        w_sel_dft  = sel_dec & (w_addr_port == DFT);
        w_ds_start = HREADYS & w_sel_dft & trans_dec[1];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_data_port <= '0;
        else if (HREADYS)
            r_data_port <= w_addr_port;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_ds_state <= DS_IDLE;
        else
            r_ds_state <= w_ds_next;
    end

    always_comb begin
        w_ds_next = r_ds_state;
        case (r_ds_state)
            DS_IDLE: if (w_ds_start) w_ds_next = DS_ERR1;
            DS_ERR1: w_ds_next = DS_ERR2;
            DS_ERR2: if (HREADYS) w_ds_next = w_ds_start ? DS_ERR1 : DS_IDLE;
            default: w_ds_next = DS_IDLE;
        endcase
    end

    always_comb begin
        w_ds_ready = 1'b1;
        w_ds_resp  = OKAY;
        case (r_ds_state)
            DS_ERR1: begin
                w_ds_ready = 1'b0;
                w_ds_resp  = ERROR;
            end
            DS_ERR2: w_ds_resp = ERROR;
            default: ;
        endcase
    end

    always_comb begin
        HREADYOUTS = w_ds_ready;
        HRESPS     = w_ds_resp;
        HRDATAS    = '0;
        HRUSERS    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_data_port == PW'(i)) begin
                HREADYOUTS = readyout_dec[i];
                HRESPS     = resp_dec[2*i +: 2];
                HRDATAS    = rdata_dec[DATA_W*i +: DATA_W];
                HRUSERS    = ruser_dec[USER_W*i +: USER_W];
            end
        end
    end

`ifdef DECODE_ERR_CAPTURE_EN
    logic          r_err_flag;
    logic [AW-1:0] r_err_addr;
    logic          w_err_new;

    assign w_err_new = (r_ds_state == DS_IDLE) && (w_ds_next == DS_ERR1);

    // A fresh error in the same cycle as err_clr keeps the flag set
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_err_flag <= 1'b0;
            r_err_addr <= '0;
        end else if (w_err_new) begin
            if (!r_err_flag)
                r_err_addr <= decode_addr_dec;
            r_err_flag <= 1'b1;
        end else if (err_clr) begin
            r_err_flag <= 1'b0;
        end
    end

    assign err_flag = r_err_flag;
    assign err_addr = r_err_addr;
`endif

endmodule

// File: tb/tb_ahb_matrix_decoder_param.sv
// Randomised bench for ahb_matrix_decoder_param against a region-table reference model.
// Directed test-plan sequences run first, then a long random phase.
module tb_ahb_matrix_decoder_param;

    localparam int NP = 3;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam int UW = 32;

    logic              HCLK = 1'b0;
    logic              HRESETn = 1'b0;
    logic [0:0]        remapping_dec;
    logic              HREADYS;
    logic              sel_dec;
    logic [AW-1:0]     decode_addr_dec;
    logic [1:0]        trans_dec;
    logic [NP-1:0]     active_dec_in;
    logic [NP-1:0]     readyout_dec;
    logic [2*NP-1:0]   resp_dec;
    logic [DW*NP-1:0]  rdata_dec;
    logic [UW*NP-1:0]  ruser_dec;
    logic [NP-1:0]     sel_dec_out;
    logic              active_dec;
    logic              HREADYOUTS;
    logic [1:0]        HRESPS;
    logic [DW-1:0]     HRDATAS;
    logic [UW-1:0]     HRUSERS;
`ifdef DECODE_ERR_CAPTURE_EN
    logic              err_clr = 1'b0;
    logic              err_flag;
    logic [AW-1:0]     err_addr;
`endif

    ahb_matrix_decoder_param dut (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .remapping_dec   (remapping_dec),
        .HREADYS         (HREADYS),
        .sel_dec         (sel_dec),
        .decode_addr_dec (decode_addr_dec),
        .trans_dec       (trans_dec),
        .active_dec_in   (active_dec_in),
        .readyout_dec    (readyout_dec),
        .resp_dec        (resp_dec),
        .rdata_dec       (rdata_dec),
        .ruser_dec       (ruser_dec),
        .sel_dec_out     (sel_dec_out),
        .active_dec      (active_dec),
        .HREADYOUTS      (HREADYOUTS),
        .HRESPS          (HRESPS),
        .HRDATAS         (HRDATAS),
        .HRUSERS         (HRUSERS)
`ifdef DECODE_ERR_CAPTURE_EN
        ,
        .err_clr         (err_clr),
        .err_flag        (err_flag),
        .err_addr        (err_addr)
`endif
    );

    always #5 HCLK = ~HCLK;

    int errs   = 0;
    int checks = 0;

    int m_base [5] = '{'h000000, 'h000000, 'h0C0000, 'h140000, 'h200000};
    int m_lim  [5] = '{'h00007F, 'h0BFFFF, 'h13FFFF, 'h1FFFFF, 'h27FFFF};
    int m_port [5] = '{1, 0, 1, 1, 2};
    int m_rmp  [5] = '{1, 0, 0, 0, 0};
    int m_picks[12] = '{'h000000, 'h00007F, 'h000080, 'h0BFFFF, 'h0C0000,
                        'h13FFFF, 'h140000, 'h1FFFFF, 'h200000, 'h27FFFF,
                        'h280000, 'h300000};

    // Reference state: owner of the data phase and cycles of error response left
    int m_dport = 0;
    int m_err   = 0;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int m_route(input int a, input int rm);
        for (int i = 0; i < 5; i++)
            if ((m_rmp[i] == 0 || (rm & m_rmp[i]) != 0) &&
                a >= m_base[i] && a <= m_lim[i])
                return (m_port[i] >= NP) ? NP : m_port[i];
        return NP;
    endfunction

    function automatic int m_target();
        if (trans_dec == 2'b00) return m_dport;
        return m_route(int'(decode_addr_dec), int'(remapping_dec));
    endfunction

    task automatic settle_check();
        int p;
        logic [NP-1:0] es;
        #1;
        p  = m_target();
        es = '0;
        if (sel_dec && p < NP) es[p] = 1'b1;
        chk("sel_dec_out", sel_dec_out, es);
        if (p == NP) chk("active_dft", active_dec, 1);
        else         chk("active", active_dec, active_dec_in[p]);
        if (m_dport == NP) begin
            chk("ds_ready", HREADYOUTS, (m_err == 2) ? 0 : 1);
            chk("ds_resp", HRESPS, (m_err != 0) ? 1 : 0);
            chk("ds_rdata", HRDATAS, 0);
            chk("ds_ruser", HRUSERS, 0);
        end else begin
            chk("ready", HREADYOUTS, readyout_dec[m_dport]);
            chk("resp", HRESPS, resp_dec[2*m_dport +: 2]);
            chk("rdata", HRDATAS, rdata_dec[DW*m_dport +: DW]);
            chk("ruser", HRUSERS, ruser_dec[UW*m_dport +: UW]);
        end
    endtask

    // An error response lasts two cycles; m_err counts them down 2 -> 1 -> 0
    task automatic advance();
        int  p;
        bit  start;
        p     = m_target();
        start = HREADYS && sel_dec && (p == NP) && trans_dec[1];
        if (m_err == 2)   m_err = 1;
        else if (HREADYS) m_err = start ? 2 : 0;
        if (HREADYS) m_dport = p;
        @(negedge HCLK);
    endtask

    task automatic drive(input bit s, input int a, input bit [1:0] t,
                         input bit hr, input bit rm);
        sel_dec         = s;
        decode_addr_dec = AW'(a);
        trans_dec       = t;
        HREADYS         = hr;
        remapping_dec   = rm;
    endtask

    task automatic rand_slaves();
        rdata_dec     = {$urandom, $urandom, $urandom};
        ruser_dec     = {$urandom, $urandom, $urandom};
        resp_dec      = 6'($urandom);
        readyout_dec  = 3'($urandom);
        active_dec_in = 3'($urandom);
    endtask

    initial begin
        rand_slaves();
        drive(0, 0, 2'b00, 1, 0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;

        readyout_dec = 3'b001;
        resp_dec     = 6'b110100;
        settle_check();
        chk("rst_ready", HREADYOUTS, 1);
        chk("rst_resp", HRESPS, 2'b00);
        chk("rst_sel", sel_dec_out, 0);
        advance();

        drive(1, 'h0C0000, 2'b10, 1, 0);
        settle_check();
        chk("tp1_sel", sel_dec_out, 3'b010);
        advance();
        drive(0, 0, 2'b00, 1, 0);
        readyout_dec[1]  = 1'b1;
        resp_dec[3:2]    = 2'b00;
        settle_check();
        chk("tp1_ready", HREADYOUTS, 1);
        chk("tp1_rdata", HRDATAS, rdata_dec[63:32]);
        advance();

        drive(1, 'h00007F, 2'b10, 1, 1);
        settle_check();
        chk("tp2_remap1", sel_dec_out, 3'b010);
        advance();
        drive(1, 'h00007F, 2'b10, 1, 0);
        settle_check();
        chk("tp2_remap0", sel_dec_out, 3'b001);
        advance();
        drive(1, 'h000080, 2'b10, 1, 1);
        settle_check();
        chk("tp2_above", sel_dec_out, 3'b001);
        advance();

        drive(1, 'h280000, 2'b10, 1, 0);
        settle_check();
        chk("tp3_sel", sel_dec_out, 0);
        chk("tp3_active", active_dec, 1);
        advance();
        drive(1, 'h280000, 2'b10, 0, 0);
        settle_check();
        chk("tp3_err1", {HREADYOUTS, HRESPS}, 3'b001);
        advance();
        drive(1, 'h280000, 2'b10, 1, 0);
        settle_check();
        chk("tp3_err2", {HREADYOUTS, HRESPS}, 3'b101);
        advance();
        drive(1, 'h280000, 2'b10, 0, 0);
        settle_check();
        chk("tp3_reenter", {HREADYOUTS, HRESPS}, 3'b001);
        advance();
        drive(0, 0, 2'b00, 1, 0);
        settle_check();
        advance();
        drive(1, 'h280000, 2'b00, 1, 0);
        settle_check();
        chk("tp3_idle_okay", {HREADYOUTS, HRESPS}, 3'b100);
        advance();

        drive(1, 'h200000, 2'b10, 1, 0);
        settle_check();
        advance();
        readyout_dec[2] = 1'b1;
        resp_dec[5:4]   = 2'b00;
        drive(1, 'h300000, 2'b00, 1, 0);
        settle_check();
        chk("tp4_hold", sel_dec_out, 3'b100);
        chk("tp4_okay", {HREADYOUTS, HRESPS}, 3'b100);
        advance();
        drive(0, 0, 2'b00, 1, 0);
        settle_check();
        chk("tp4_noerr", HRESPS, 2'b00);
        advance();

        drive(1, 'h000100, 2'b10, 1, 0);
        settle_check();
        advance();
        readyout_dec[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 'h200000, 2'b10, 0, 0);
            settle_check();
            chk("tp5_frozen", HREADYOUTS, 0);
            advance();
        end

        drive(1, 'h280000, 2'b10, 1, 0);
        settle_check();
        advance();
        readyout_dec[0] = 1'b1;
        resp_dec[1:0]   = 2'b00;
        drive(1, 'h280000, 2'b10, 0, 0);
        settle_check();
        chk("tp5_in_err1", HREADYOUTS, 0);
        #1 HRESETn = 1'b0;
        #1;
        chk("tp5_rst_ready", HREADYOUTS, 1);
        chk("tp5_rst_resp", HRESPS, 2'b00);
        m_dport = 0;
        m_err   = 0;
        @(negedge HCLK);
        HRESETn = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            int a;
            rand_slaves();
            a = ($urandom_range(0, 3) == 0) ? int'(22'($urandom))
                                            : m_picks[$urandom_range(0, 11)];
            drive($urandom_range(0, 3) != 0, a, 2'($urandom),
                  $urandom_range(0, 3) != 0, 1'($urandom));
            settle_check();
            advance();
        end

`ifdef DECODE_ERR_CAPTURE_EN
        err_clr = 1'b1;
        drive(0, 0, 2'b00, 1, 0);
        settle_check();
        advance();
        settle_check();
        advance();
        err_clr = 1'b0;
        chk("cap_cleared", err_flag, 0);
        drive(1, 'h280000, 2'b10, 1, 0);
        settle_check();
        advance();
        drive(1, 'h280000, 2'b10, 0, 0);
        settle_check();
        advance();
        drive(1, 'h300000, 2'b10, 1, 0);
        settle_check();
        advance();
        #1;
        chk("cap_flag", err_flag, 1);
        chk("cap_addr", err_addr, 'h280000);
        err_clr = 1'b1;
        drive(0, 0, 2'b00, 0, 0);
        settle_check();
        advance();
        err_clr = 1'b0;
        #1;
        chk("cap_clr", err_flag, 0);
        chk("cap_addr_kept", err_addr, 'h280000);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
